weight_fetch_ctrl: RTL and testbench

- Read-side controller for the 100-bit weight SRAM (25 weights x 4 bits per row).
- On a start command it streams `num_rows` consecutive rows from `base_addr` and absorbs the SRAM's 1-cycle registered read latency in a credit-managed FIFO.
- It presents each row to the downstream conv/FC PE array over a valid/ready handshake.
- Sits between the weight SRAM and the PE weight-load port.

---
 rtl/weight_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM read controller: streams a row range into a credit-managed FIFO
// feeding the PE weight-load port. Optional stall counter: WFETCH_STALL_CNT_EN.
module weight_fetch_ctrl #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 100,
  parameter int LEN_W      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_rows,
  input  logic              abort,
  output logic              sram_csb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              done
`ifdef WFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_raddr;
  logic [LEN_W-1:0]  r_rem_cnt;
  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_idx;
  logic [PTR_W-1:0]  r_rd_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic w_busy;
  logic w_abort;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_start_ok;

  assign w_busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_abort    = abort && w_busy;
  assign w_start_ok = (r_state == S_IDLE) && start;
  // Credit uses registered occupancy only, so a same-cycle pop never frees a slot.
  assign w_issue    = (r_state == S_FETCH) && !abort && (r_rem_cnt != '0) &&
                      ((r_cnt + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH));
  assign w_push     = r_inflight;
  assign w_pop      = (r_cnt != '0) && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (start) w_state_nxt = (num_rows == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (abort) w_state_nxt = S_IDLE;
        else if (w_issue && (r_rem_cnt == LEN_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN:
        if (abort) w_state_nxt = S_IDLE;
        else if (!r_inflight && ((r_cnt - CNT_W'(w_pop)) == '0)) w_state_nxt = S_DONE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_raddr    <= '0;
      r_rem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_cnt      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start_ok) begin
        r_rd_ptr  <= base_addr;
        r_rem_cnt <= num_rows;
      end else if (w_issue) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rem_cnt <= r_rem_cnt - 1'b1;
        r_raddr   <= r_rd_ptr;
      end
      if (w_abort) begin
        r_wr_idx <= '0;
        r_rd_idx <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_idx] <= sram_rdata;
          r_wr_idx        <= r_wr_idx + 1'b1;
        end
        if (w_pop) r_rd_idx <= r_rd_idx + 1'b1;
        r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Address holds the last issued row between issues.
  assign sram_csb   = !w_issue;
  assign sram_raddr = w_issue ? r_rd_ptr : r_raddr;
  assign w_valid    = (r_cnt != '0);
  assign w_data     = r_mem[r_rd_idx];
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);

`ifdef WFETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (w_busy && w_valid && !w_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a 1-cycle registered SRAM model.
module tb_weight_fetch_ctrl;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 100;
  localparam int LEN_W      = 15;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  num_rows = '0;
  logic              abort = 1'b0;
  logic              sram_csb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic [DATA_W-1:0] w_data;
  logic              busy;
  logic              done;
`ifdef WFETCH_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .abort(abort), .sram_csb(sram_csb),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .busy(busy), .done(done)
`ifdef WFETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 17'h15555, a + 17'd1, 32'(a) * 32'h01000193};
  endfunction

  always @(posedge clk) if (!sram_csb) sram_rdata <= row_of(sram_raddr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0;
    repeat (3) step();
    #1;
    checks += 6;
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL reset_csb got=%b exp=1", sram_csb); end
    if (sram_raddr !== '0) begin errors++; $display("FAIL reset_raddr got=%h exp=0", sram_raddr); end
    if (w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", w_valid); end
    if (w_data !== '0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", w_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [ADDR_W-1:0] ea;
    base_addr = 17'd21; num_rows = 15'd4; w_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      ea = ADDR_W'(21 + ((k <= 4) ? k - 1 : 3));
      checks += 5;
      if (sram_csb !== !(k <= 4)) begin errors++; $display("FAIL stream_csb k=%0d got=%b", k, sram_csb); end
      if (sram_raddr !== ea) begin errors++; $display("FAIL stream_raddr k=%0d got=%0d exp=%0d", k, sram_raddr, ea); end
      if (w_valid !== (k >= 3 && k <= 6)) begin errors++; $display("FAIL stream_valid k=%0d got=%b", k, w_valid); end
      if (done !== (k == 7)) begin errors++; $display("FAIL stream_done k=%0d got=%b", k, done); end
      if (busy !== (k <= 6)) begin errors++; $display("FAIL stream_busy k=%0d got=%b", k, busy); end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (w_data !== row_of(ADDR_W'(21 + k - 3))) begin
          errors++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, w_data, row_of(ADDR_W'(21 + k - 3)));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int issues = 0;
    int nrx = 0;
    int ndone = 0;
    base_addr = 17'd1100; num_rows = 15'd8; w_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (!sram_csb) issues++;
      if (c == 10) begin
        checks += 3;
        if (issues != 4) begin errors++; $display("FAIL bp_stall_issues got=%0d exp=4", issues); end
        if (w_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got=%b exp=1", w_valid); end
        if (w_data !== row_of(17'd1100)) begin errors++; $display("FAIL bp_stall_data got=%h exp=%h", w_data, row_of(17'd1100)); end
      end
      step();
    end
    w_ready = 1'b1;
    for (int c = 0; c < 60 && ndone == 0; c++) begin
      #1;
      if (!sram_csb) issues++;
      if (done) ndone++;
      if (w_valid && w_ready) begin
        checks++;
        if (nrx >= 8 || w_data !== row_of(ADDR_W'(1100 + nrx))) begin
          errors++; $display("FAIL bp_row idx=%0d got=%h exp=%h", nrx, w_data, row_of(ADDR_W'(1100 + nrx)));
        end
        nrx++;
      end
      step();
    end
    checks += 3;
    if (nrx != 8) begin errors++; $display("FAIL bp_rows got=%0d exp=8", nrx); end
    if (issues != 8) begin errors++; $display("FAIL bp_issues got=%0d exp=8", issues); end
    if (ndone != 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", ndone); end
`ifdef WFETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd8) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=8", stall_cnt); end
`endif
  endtask

  task automatic test_zero_len();
    num_rows = '0; base_addr = 17'd7; start = 1'b1;
    #1;
    checks++;
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL zero_csb0 got=%b exp=1", sram_csb); end
    step();
    start = 1'b0;
    #1;
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL zero_csb1 got=%b exp=1", sram_csb); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy); end
    step();
    #1;
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done2 got=%b exp=0", done); end
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL zero_csb2 got=%b exp=1", sram_csb); end
  endtask

  task automatic test_abort();
    int ndone = 0;
    base_addr = 17'd17100; num_rows = 15'd16; w_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    #1;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got=%b exp=1", busy); end
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL abort_csb_cycle got=%b exp=1", sram_csb); end
    step();
    abort = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (w_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", w_valid); end
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL abort_csb got=%b exp=1", sram_csb); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    for (int c = 0; c < 3; c++) begin
      step();
      if (done || w_valid) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_quiet got=%0d exp=0", ndone); end
    base_addr = 17'd20; num_rows = 15'd1; start = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks += 2;
    if (sram_csb !== 1'b0) begin errors++; $display("FAIL restart_csb got=%b exp=0", sram_csb); end
    if (sram_raddr !== 17'd20) begin errors++; $display("FAIL restart_raddr got=%0d exp=20", sram_raddr); end
    step();
    step();
    #1;
    checks += 2;
    if (w_valid !== 1'b1) begin errors++; $display("FAIL restart_valid got=%b exp=1", w_valid); end
    if (w_data !== row_of(17'd20)) begin errors++; $display("FAIL restart_data got=%h exp=%h", w_data, row_of(17'd20)); end
    step();
    #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b exp=1", done); end
    step();
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] ea;
    base_addr = 17'h1FFFE; num_rows = 15'd3; w_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k <= 3) begin
        ea = ADDR_W'(17'h1FFFE + k - 1);
        checks += 2;
        if (sram_csb !== 1'b0) begin errors++; $display("FAIL wrap_csb k=%0d got=%b exp=0", k, sram_csb); end
        if (sram_raddr !== ea) begin errors++; $display("FAIL wrap_raddr k=%0d got=%h exp=%h", k, sram_raddr, ea); end
      end
      if (k >= 3 && k <= 5) begin
        ea = ADDR_W'(17'h1FFFE + k - 3);
        checks += 2;
        if (w_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid k=%0d got=%b exp=1", k, w_valid); end
        if (w_data !== row_of(ea)) begin errors++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, w_data, row_of(ea)); end
      end
      if (k == 6) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%b exp=1", done); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_job();
    int bad = 0;
    base_addr = 17'd500; num_rows = 15'd4; w_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #1;
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy); end
    if (w_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid_pre got=%b exp=1", w_valid); end
    rst_n = 1'b0;
    step();
    #1;
    checks += 6;
    if (sram_csb !== 1'b1) begin errors++; $display("FAIL rstmid_csb got=%b exp=1", sram_csb); end
    if (sram_raddr !== '0) begin errors++; $display("FAIL rstmid_raddr got=%h exp=0", sram_raddr); end
    if (w_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", w_valid); end
    if (w_data !== '0) begin errors++; $display("FAIL rstmid_wdata got=%h exp=0", w_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
    rst_n = 1'b1; w_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done || w_valid || !sram_csb) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_wrap();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
